// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU encodings and EX-slot helpers for the MIPS pipeline
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int REG_W = 5;
   localparam int ALUC_W = 3;
   localparam int CNT_W = 16;
   typedef enum logic [ALUC_W-1:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_t;
   typedef enum logic {EX_BUBBLE = 1'b0, EX_LOADED = 1'b1} ex_state_t;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + CNT_W'(1);
   endfunction
endpackage

// File: rtl/id_ex_register_if.sv
// id_ex_register_if: decode-side inputs, hazard controls and registered EX-side outputs
interface id_ex_register_if #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int REG_W  = mips_pkg::REG_W,
   parameter int ALUC_W = mips_pkg::ALUC_W
);
   logic              FlushE, StallE, ValidD;
   logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
   logic [ALUC_W-1:0] ALUControlD;
   logic [DATA_W-1:0] RD1D, RD2D, SignImmD;
   logic [REG_W-1:0]  RsD, RtD, RdD;
   logic              ValidE;
   logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [ALUC_W-1:0] ALUControlE;
   logic [DATA_W-1:0] RD1E, RD2E, SignImmE;
   logic [REG_W-1:0]  RsE, RtE, RdE;
   logic [15:0]       BubbleCount;
   modport master (
      output FlushE, StallE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
             ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
      input  ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
             ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, BubbleCount
   );
   modport slave (
      input  FlushE, StallE, ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
             ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD,
      output ValidE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
             ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, BubbleCount
   );
endinterface

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr: width-parameterised register with synchronous clear and enable
module pipe_reg_en_clr #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] r_d, r_q;
   always_comb r_d = clr ? '0 : en ? d : r_q;
   always_ff @(posedge clk) begin
      if (rst) r_q <= '0;
      else r_q <= r_d;
   end
   assign q = r_q;
endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with flush, stall, valid gating and bubble counter
module id_ex_register #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int REG_W  = mips_pkg::REG_W,
   parameter int ALUC_W = mips_pkg::ALUC_W
) (
   input logic              clk,
   input logic              rst,
   id_ex_register_if.slave  bus
);
   import mips_pkg::*;
   localparam int CTRL_W = ALUC_W + 5;
   ex_state_t          state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [CTRL_W-1:0]  ctrl_d, ctrl_q;
   logic [3*DATA_W-1:0] data_q;
   logic [3*REG_W-1:0] idx_q;
   logic               load_en, bubble;
   always_comb begin
      load_en = ~bus.StallE;
      bubble  = bus.FlushE | (load_en & ~bus.ValidD);
      state_d = bus.FlushE ? EX_BUBBLE : !load_en ? state_q : bus.ValidD ? EX_LOADED : EX_BUBBLE;
      cnt_d   = bubble ? sat_inc(cnt_q) : cnt_q;
      ctrl_d  = bus.ValidD ? {bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.ALUSrcD,
                              bus.RegDstD, bus.ALUControlD} : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EX_BUBBLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // Controls are pre-gated by ValidD so an invalid slot can never write state downstream
   pipe_reg_en_clr #(.W(CTRL_W)) u_ctrl (
      .clk(clk), .rst(rst), .en(load_en), .clr(bus.FlushE), .d(ctrl_d), .q(ctrl_q)
   );
   pipe_reg_en_clr #(.W(3*DATA_W)) u_data (
      .clk(clk), .rst(rst), .en(load_en), .clr(bus.FlushE),
      .d({bus.RD1D, bus.RD2D, bus.SignImmD}), .q(data_q)
   );
   pipe_reg_en_clr #(.W(3*REG_W)) u_idx (
      .clk(clk), .rst(rst), .en(load_en), .clr(bus.FlushE),
      .d({bus.RsD, bus.RtD, bus.RdD}), .q(idx_q)
   );
   assign bus.ValidE = state_q == EX_LOADED;
   assign {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE, bus.RegDstE,
           bus.ALUControlE} = ctrl_q;
   assign {bus.RD1E, bus.RD2E, bus.SignImmE} = data_q;
   assign {bus.RsE, bus.RtE, bus.RdE} = idx_q;
   assign bus.BubbleCount = cnt_q;
endmodule

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: randomized and directed checks of id_ex_register against a behavioural model
module tb_id_ex_register;
   import mips_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   id_ex_register_if bus ();
   id_ex_register dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic        e_valid;
   logic [7:0]  e_ctrl;
   logic [31:0] e_rd1, e_rd2, e_imm;
   logic [4:0]  e_rs, e_rt, e_rd;
   int          e_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      check("ValidE", 32'(bus.ValidE), 32'(e_valid));
      check("ctrlE", 32'({bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ALUSrcE,
                          bus.RegDstE, bus.ALUControlE}), 32'(e_ctrl));
      check("RD1E", bus.RD1E, e_rd1);
      check("RD2E", bus.RD2E, e_rd2);
      check("SignImmE", bus.SignImmE, e_imm);
      check("RsE", 32'(bus.RsE), 32'(e_rs));
      check("RtE", 32'(bus.RtE), 32'(e_rt));
      check("RdE", 32'(bus.RdE), 32'(e_rd));
      check("BubbleCount", 32'(bus.BubbleCount), 32'(e_cnt));
   endtask

   task automatic clear_e();
      e_valid = 0; e_ctrl = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0;
   endtask

   // Behavioural view of one clock edge: reset, then flush, then stall, then load
   task automatic model();
      if (rst) begin
         clear_e();
         e_cnt = 0;
      end else if (bus.FlushE) begin
         clear_e();
         if (e_cnt < 65535) e_cnt = e_cnt + 1;
      end else if (!bus.StallE) begin
         e_valid = bus.ValidD;
         e_ctrl  = bus.ValidD ? {bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.ALUSrcD,
                                 bus.RegDstD, bus.ALUControlD} : 8'h00;
         e_rd1 = bus.RD1D; e_rd2 = bus.RD2D; e_imm = bus.SignImmD;
         e_rs = bus.RsD; e_rt = bus.RtD; e_rd = bus.RdD;
         if (!bus.ValidD && e_cnt < 65535) e_cnt = e_cnt + 1;
      end
   endtask

   task automatic step(input logic r, input logic f, input logic s, input bit chk = 1'b1);
      rst = r; bus.FlushE = f; bus.StallE = s;
      @(posedge clk);
      model();
      #1;
      if (chk) check_all();
   endtask

   task automatic rand_d();
      bus.ValidD = 1'($urandom); bus.RegWriteD = 1'($urandom); bus.MemtoRegD = 1'($urandom);
      bus.MemWriteD = 1'($urandom); bus.ALUSrcD = 1'($urandom); bus.RegDstD = 1'($urandom);
      bus.ALUControlD = 3'($urandom);
      bus.RD1D = $urandom; bus.RD2D = $urandom; bus.SignImmD = $urandom;
      bus.RsD = 5'($urandom); bus.RtD = 5'($urandom); bus.RdD = 5'($urandom);
   endtask

   initial begin
      logic r, f, s;
      clear_e();
      e_cnt = 0;
      rand_d();
      step(1, 0, 0);
      step(1, 1, 1);
      // lw decode
      rand_d();
      bus.ValidD = 1; bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.MemWriteD = 0;
      bus.ALUSrcD = 1; bus.RegDstD = 0; bus.ALUControlD = ALU_ADD;
      bus.RD1D = 32'h0000_1000; bus.SignImmD = 32'h4; bus.RtD = 5'd8;
      step(0, 0, 0);
      check("lw_valid", 32'(bus.ValidE), 32'd1);
      check("lw_rt", 32'(bus.RtE), 32'd8);
      check("lw_rd1", bus.RD1E, 32'h0000_1000);
      check("lw_cnt", 32'(bus.BubbleCount), 32'd0);
      // R-type with RdD=3, then held through a 3-cycle stall
      rand_d();
      bus.ValidD = 1; bus.RegDstD = 1; bus.RdD = 5'd3;
      step(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         rand_d();
         step(0, 0, 1);
         check("stall_rd", 32'(bus.RdE), 32'd3);
         check("stall_cnt", 32'(bus.BubbleCount), 32'd0);
      end
      // sw in D with flush and stall on the same edge
      rand_d();
      bus.ValidD = 1; bus.MemWriteD = 1; bus.RegWriteD = 0; bus.RtD = 5'd9;
      step(0, 1, 1);
      check("fs_memwrite", 32'(bus.MemWriteE), 32'd0);
      check("fs_rt", 32'(bus.RtE), 32'd0);
      check("fs_valid", 32'(bus.ValidE), 32'd0);
      check("fs_cnt", 32'(bus.BubbleCount), 32'd1);
      // invalid slot with write controls set
      rand_d();
      bus.ValidD = 0; bus.RegWriteD = 1; bus.MemWriteD = 1;
      step(0, 0, 0);
      check("inv_regwrite", 32'(bus.RegWriteE), 32'd0);
      check("inv_memwrite", 32'(bus.MemWriteE), 32'd0);
      check("inv_valid", 32'(bus.ValidE), 32'd0);
      check("inv_cnt", 32'(bus.BubbleCount), 32'd2);
      // random mix
      repeat (400) begin
         rand_d();
         r = $urandom_range(0, 49) == 0;
         f = $urandom_range(0, 9) == 0;
         s = $urandom_range(0, 4) == 0;
         step(r, f, s);
      end
      // reset during stall discards held contents; next load is normal
      rand_d(); bus.ValidD = 1;
      step(0, 0, 0);
      rand_d();
      step(0, 0, 1);
      step(1, 0, 1);
      check("rst_stall_valid", 32'(bus.ValidE), 32'd0);
      rand_d(); bus.ValidD = 1;
      step(0, 0, 0);
      check("post_rst_valid", 32'(bus.ValidE), 32'd1);
      // saturation
      step(1, 0, 0);
      repeat (65534) step(0, 1, 0, 1'b0);
      check("sat_pre", 32'(bus.BubbleCount), 32'h0000_FFFE);
      step(0, 1, 0);
      check("sat_max", 32'(bus.BubbleCount), 32'h0000_FFFF);
      step(0, 1, 1);
      check("sat_hold", 32'(bus.BubbleCount), 32'h0000_FFFF);
      rand_d(); bus.ValidD = 1;
      step(0, 0, 0);
      step(0, 0, 1);
      step(1, 0, 1);
      check("sat_rst_cnt", 32'(bus.BubbleCount), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DATA_W, 32, datapath and immediate width
  REG_W, 5, register-index width
  ALUC_W, 3, ALU control width
REQ-002 Ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  FlushE  in  1  hazard-unit request to insert a bubble into EX
  StallE  in  1  hold current EX contents
  ValidD  in  1  decode slot carries a real instruction
  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control bits
  ALUControlD  in  ALUC_W  decoded ALU operation
  RD1D, RD2D  in  DATA_W  register-file read data
  SignImmD  in  DATA_W  sign-extended immediate
  RsD, RtD, RdD  in  REG_W  source/destination indices
  ValidE  out  1  EX slot holds a real instruction
  RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  registered controls
  ALUControlE  out  ALUC_W  registered ALU operation
  RD1E, RD2E, SignImmE  out  DATA_W  registered operands
  RsE, RtE, RdE  out  REG_W  registered indices
  BubbleCount  out  16  saturating count of bubbles inserted since reset

Function
REQ-003 Every output SHALL be a flop output; no combinational path from any input to any output.
REQ-004 Latency SHALL be exactly one cycle: values on D inputs at edge N appear on E outputs after edge N when neither FlushE nor StallE is asserted.
REQ-005 Load (FlushE=0, StallE=0): all E outputs SHALL capture their D counterparts; ValidE SHALL capture ValidD.
REQ-006 Stall (FlushE=0, StallE=1): all E outputs and BubbleCount SHALL hold.
REQ-007 Flush (FlushE=1): all E outputs SHALL clear to zero (ValidE=0, controls 0, data 0, indices 0), regardless of StallE.
REQ-008 Priority SHALL be rst > FlushE > StallE > load.
REQ-009 A cleared slot SHALL be architecturally inert: RegWriteE=0, MemWriteE=0, RtE=RdE=0 so forwarding never matches.
REQ-010 Load with ValidD=0 SHALL force all control outputs to 0 (data/indices still captured).
REQ-011 BubbleCount SHALL increment by 1 on each edge where FlushE=1, or load occurs with ValidD=0; it SHALL saturate at 16'hFFFF.
REQ-012 Stall with FlushE=0 SHALL NOT change BubbleCount even if ValidD=0.
REQ-013 Block state is two-valued: Loaded (ValidE=1) and Bubble (ValidE=0); transitions only per REQ-005..REQ-008.

Reset
REQ-014 With rst=1 at a rising edge, all outputs SHALL become 0, including BubbleCount, overriding FlushE/StallE.
REQ-015 rst asserted mid-stall SHALL discard held contents; first load after rst deasserts SHALL behave as REQ-005.

Structure
REQ-016 Widths DATA_W, REG_W, ALUC_W and ALU control encodings SHALL live in shared package mips_pkg, used also by decode and EX.
REQ-017 One sub-module SHALL be used: pipe_reg_en_clr (width-parameterised register with synchronous clear and enable), instantiated per field group; counter logic stays in the top.

Verification
REQ-018 Load: lw decode (RegWriteD=1, MemtoRegD=1, ALUSrcD=1, RD1D=32'h0000_1000, SignImmD=32'h4, RtD=5'd8, ValidD=1) -> next cycle same values on E outputs, ValidE=1, BubbleCount=0.
REQ-019 Stall: load R-type RdD=5'd3, then StallE=1 for 3 cycles while D inputs change -> E outputs keep RdE=3 throughout; BubbleCount unchanged.
REQ-020 Flush+stall: FlushE=1 and StallE=1 on same edge with sw in D -> MemWriteE=0, RtE=0, ValidE=0, BubbleCount increments by 1.
REQ-021 Invalid slot: ValidD=0 with RegWriteD=1, MemWriteD=1 -> RegWriteE=0, MemWriteE=0, ValidE=0, BubbleCount +1.
REQ-022 Saturation/reset: preload count to 16'hFFFE via 2 more flushes -> BubbleCount=16'hFFFF and stays on further flush; rst=1 during stall -> all outputs 0 next edge.
